imem_arbiter: RTL

Two-port arbiter and sequencer for the 256-word instruction memory of the multicycle RISC-V core. It shares one synchronous-read memory port between the CPU fetch requester and a debug/boot-loader requester. Two-way round-robin arbitration decides grants, and each access runs through a three-state sequence. Misaligned and out-of-range addresses return an error response without touching memory. The block sits between the fetch stage, the debug loader and the IMEM array.

---
 rtl/imem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Round-robin arbiter and three-state sequencer sharing one IMEM port between fetch and debug.
// Define IMEM_ARB_DBG_WRITE_EN to allow debug writes; otherwise debug writes return an error.
module imem_arbiter #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  f_req,
    input  logic [31:0]           f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [31:0]           f_rdata,
    output logic                  f_rerr,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  d_rerr,
    output logic                  m_en,
    output logic                  m_we,
    output logic [DEPTH_LOG2-1:0] m_addr,
    output logic [31:0]           m_wdata,
    input  logic [31:0]           m_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic FETCH = 1'b0;
    localparam logic DEBUG = 1'b1;

    state_t state;
    logic   last;
    logic   owner;
    logic   pend_we;

    logic        f_ok;
    logic        d_ok;
    logic        pick_debug;
    logic        grant_f;
    logic        grant_d;
    logic        grant_any;
    logic        grant_ok;
    logic        grant_we;
    logic [31:0] grant_addr;

    // Word aligned and inside the array; anything above the top index bit is out of range.
    function automatic logic addr_ok(input logic [31:0] addr);
        logic [31:0] hi;
        hi = addr >> (DEPTH_LOG2 + 2);
        return (addr[1:0] == 2'b00) && (hi == 32'd0);
    endfunction

    always_comb begin
        f_ok = addr_ok(f_addr);
`ifdef IMEM_ARB_DBG_WRITE_EN
        d_ok     = addr_ok(d_addr);
        grant_we = 1'b0;
`else
        d_ok     = addr_ok(d_addr) && !d_we;
        grant_we = 1'b0;
`endif
        pick_debug = d_req && (!f_req || (last == FETCH));
        grant_f    = (state == IDLE) && f_req && !pick_debug;
        grant_d    = (state == IDLE) && pick_debug;
        grant_any  = grant_f || grant_d;
        grant_ok   = grant_d ? d_ok : f_ok;
        grant_addr = grant_d ? d_addr : f_addr;
`ifdef IMEM_ARB_DBG_WRITE_EN
        grant_we   = grant_d && d_we;
`endif
    end

    always_comb begin
        f_gnt   = grant_f;
        d_gnt   = grant_d;
        m_en    = grant_any && grant_ok;
`ifdef IMEM_ARB_DBG_WRITE_EN
        m_we    = m_en && grant_we;
`else
        m_we    = 1'b0;
`endif
        m_addr  = m_en ? grant_addr[DEPTH_LOG2+1:2] : '0;
        m_wdata = (m_en && grant_d) ? d_wdata : '0;
    end

    // Error responses skip ACCESS; write acknowledgements carry zero data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            last     <= DEBUG;
            owner    <= FETCH;
            pend_we  <= 1'b0;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
            f_rerr   <= 1'b0;
            d_rerr   <= 1'b0;
        end else begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last    <= grant_d ? DEBUG : FETCH;
                        owner   <= grant_d ? DEBUG : FETCH;
                        pend_we <= grant_we;
                        if (grant_ok) begin
                            state <= ACCESS;
                        end else begin
                            state <= RESP;
                            if (grant_d) begin
                                d_rdata  <= '0;
                                d_rerr   <= 1'b1;
                                d_rvalid <= 1'b1;
                            end else begin
                                f_rdata  <= '0;
                                f_rerr   <= 1'b1;
                                f_rvalid <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (owner == DEBUG) begin
                        d_rdata  <= pend_we ? 32'd0 : m_rdata;
                        d_rerr   <= 1'b0;
                        d_rvalid <= 1'b1;
                    end else begin
                        f_rdata  <= m_rdata;
                        f_rerr   <= 1'b0;
                        f_rvalid <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
